// File: rtl/peripheral_mpi_noc_arbiter_if.sv
// NoC merge bus: N requester streams in, one merged stream out, plus lock status.
// The slave modport is the arbiter side; the master modport is the endpoint/router side.
interface peripheral_mpi_noc_arbiter_if #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int N              = 2
);
    logic [N-1:0][NOC_FLIT_WIDTH-1:0] in_flit;
    logic [N-1:0]                     in_last;
    logic [N-1:0]                     in_valid;
    logic [N-1:0]                     in_ready;
    logic [NOC_FLIT_WIDTH-1:0]        out_flit;
    logic                             out_last;
    logic                             out_valid;
    logic                             out_ready;
    logic [N-1:0]                     grant;
    logic                             locked;

    modport slave (
        input  in_flit, in_last, in_valid, out_ready,
        output in_ready, out_flit, out_last, out_valid, grant, locked
    );

    modport master (
        output in_flit, in_last, in_valid, out_ready,
        input  in_ready, out_flit, out_last, out_valid, grant, locked
    );
endinterface

// File: rtl/peripheral_mpi_noc_arbiter.sv
// Packet-atomic round-robin merge of N NoC streams onto one link, registered output.
// A requester that starts a multi-flit packet owns the link until its last flit.
module peripheral_mpi_noc_arbiter_lane #(
    parameter int W = 32
) (
    input  logic         i_sel,
    input  logic         i_load_en,
    input  logic [W-1:0] i_flit,
    input  logic         i_last,
    output logic         o_ready,
    output logic [W-1:0] o_flit,
    output logic         o_last
);
    // Unselected lanes contribute zero so the top can OR-reduce without a mux tree.
    assign o_ready = i_sel & i_load_en;
    assign o_flit  = i_sel ? i_flit : '0;
    assign o_last  = i_sel & i_last;
endmodule

module peripheral_mpi_noc_arbiter #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int N              = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    peripheral_mpi_noc_arbiter_if.slave   io_noc
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                           r_state, w_state_nxt;
    logic [PW-1:0]                    r_ptr, r_owner;
    logic [PW-1:0]                    w_cand, w_sel, w_ptr_nxt;
    logic                             w_cand_vld, w_sel_vld;
    logic                             w_load_en, w_xfer, w_sel_last;
    logic [N-1:0]                     w_lane_sel, w_ready, w_lane_last;
    logic [N-1:0][NOC_FLIT_WIDTH-1:0] w_lane_flit;
    logic [NOC_FLIT_WIDTH-1:0]        w_flit;
    logic [NOC_FLIT_WIDTH-1:0]        r_out_flit;
    logic                             r_out_last, r_out_valid;
    logic [N-1:0]                     r_grant;

    // Round-robin search: lanes at or above ptr first, then wrap to the lanes below it.
    always_comb begin
        w_cand     = '0;
        w_cand_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_cand_vld && io_noc.in_valid[i] && (PW'(i) >= r_ptr)) begin
                w_cand     = PW'(i);
                w_cand_vld = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_cand_vld && io_noc.in_valid[i] && (PW'(i) < r_ptr)) begin
                w_cand     = PW'(i);
                w_cand_vld = 1'b1;
            end
        end
    end

    assign w_load_en = !r_out_valid | io_noc.out_ready;
    assign w_ptr_nxt = (w_sel == PW'(N - 1)) ? '0 : w_sel + PW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_xfer && !w_sel_last) w_state_nxt = S_LOCKED;
            S_LOCKED: if (w_xfer && w_sel_last)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: in LOCKED the owner keeps the lane even while it stalls.
    always_comb begin
        w_sel      = r_owner;
        w_sel_vld  = 1'b1;
        w_lane_sel = '0;
        if (r_state == S_IDLE) begin
            w_sel     = w_cand;
            w_sel_vld = w_cand_vld;
        end
        for (int i = 0; i < N; i++)
            w_lane_sel[i] = !rst && w_sel_vld && (w_sel == PW'(i));
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        peripheral_mpi_noc_arbiter_lane #(.W(NOC_FLIT_WIDTH)) u_lane (
            .i_sel     (w_lane_sel[gi]),
            .i_load_en (w_load_en),
            .i_flit    (io_noc.in_flit[gi]),
            .i_last    (io_noc.in_last[gi]),
            .o_ready   (w_ready[gi]),
            .o_flit    (w_lane_flit[gi]),
            .o_last    (w_lane_last[gi])
        );
    end

    always_comb begin
        w_flit = '0;
        for (int i = 0; i < N; i++) w_flit = w_flit | w_lane_flit[i];
    end

    assign w_sel_last = |w_lane_last;
    assign w_xfer     = |(io_noc.in_valid & w_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_out_flit  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_grant     <= '0;
        end else begin
            if (w_xfer) begin
                r_out_flit  <= w_flit;
                r_out_last  <= w_sel_last;
                r_out_valid <= 1'b1;
            end else if (io_noc.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_xfer && w_sel_last) begin
                r_ptr   <= w_ptr_nxt;
                r_grant <= '0;
            end else if (w_xfer && (r_state == S_IDLE)) begin
                r_owner <= w_sel;
                r_grant <= w_lane_sel;
            end
        end
    end

    assign io_noc.in_ready  = w_ready;
    assign io_noc.out_flit  = r_out_flit;
    assign io_noc.out_last  = r_out_last;
    assign io_noc.out_valid = r_out_valid;
    assign io_noc.grant     = r_grant;
    assign io_noc.locked    = (r_state == S_LOCKED);
endmodule

// File: tb/tb_peripheral_mpi_noc_arbiter.sv
// Directed bench: N=3 vector table for arbitration corners, N=2 streaming throughput run.
module tb_peripheral_mpi_noc_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    peripheral_mpi_noc_arbiter_if #(.NOC_FLIT_WIDTH(32), .N(3)) bus3();
    peripheral_mpi_noc_arbiter_if #(.NOC_FLIT_WIDTH(32), .N(2)) bus2();

    peripheral_mpi_noc_arbiter #(.NOC_FLIT_WIDTH(32), .N(3)) dut3 (
        .clk(clk), .rst(rst), .io_noc(bus3.slave));
    peripheral_mpi_noc_arbiter #(.NOC_FLIT_WIDTH(32), .N(2)) dut2 (
        .clk(clk), .rst(rst), .io_noc(bus2.slave));

    typedef struct {
        logic        r;
        logic [2:0]  v, l;
        logic [31:0] f0, f1, f2;
        logic        ordy;
        logic [2:0]  e_rdy;
        logic        e_ov;
        logic [31:0] e_of;
        logic        e_ol;
        logic [2:0]  e_gr;
        logic        e_lk;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic [2:0] v, l, input logic [31:0] f0, f1, f2,
                       input logic ordy, input logic [2:0] e_rdy, input logic e_ov,
                       input logic [31:0] e_of, input logic e_ol, input logic [2:0] e_gr,
                       input logic e_lk);
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.f0 = f0; t.f1 = f1; t.f2 = f2; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_of = e_of; t.e_ol = e_ol; t.e_gr = e_gr; t.e_lk = e_lk;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    int s_p[2], s_k[2];

    initial begin
        bus3.in_flit = '0; bus3.in_last = '0; bus3.in_valid = '0; bus3.out_ready = 1'b1;
        bus2.in_flit = '0; bus2.in_last = '0; bus2.in_valid = '0; bus2.out_ready = 1'b1;
        @(posedge clk); #1;

        // reset state
        add(1, 3'b111, 3'b111, 'hA0, 'hB0, 'hC0, 1, 3'b000, 0, 'h00, 0, 3'b000, 0);
        // single-flit round robin
        add(0, 3'b111, 3'b111, 'hA0, 'hB0, 'hC0, 1, 3'b001, 1, 'hA0, 1, 3'b000, 0);
        add(0, 3'b111, 3'b111, 'hA1, 'hB0, 'hC0, 1, 3'b010, 1, 'hB0, 1, 3'b000, 0);
        add(0, 3'b111, 3'b111, 'hA1, 'hB1, 'hC0, 1, 3'b100, 1, 'hC0, 1, 3'b000, 0);
        add(0, 3'b111, 3'b111, 'hA1, 'hB1, 'hC1, 1, 3'b001, 1, 'hA1, 1, 3'b000, 0);
        add(0, 3'b111, 3'b111, 'hA2, 'hB1, 'hC1, 1, 3'b010, 1, 'hB1, 1, 3'b000, 0);
        add(0, 3'b111, 3'b111, 'hA2, 'hB2, 'hC1, 1, 3'b100, 1, 'hC1, 1, 3'b000, 0);
        add(0, 3'b000, 3'b000, 'h00, 'h00, 'h00, 1, 3'b000, 0, 'hC1, 1, 3'b000, 0);
        // packet atomicity: req0 4 flits while req1 waits
        add(0, 3'b011, 3'b010, 'h10, 'h20, 'h00, 1, 3'b001, 1, 'h10, 0, 3'b001, 1);
        add(0, 3'b011, 3'b010, 'h11, 'h20, 'h00, 1, 3'b001, 1, 'h11, 0, 3'b001, 1);
        add(0, 3'b011, 3'b010, 'h12, 'h20, 'h00, 1, 3'b001, 1, 'h12, 0, 3'b001, 1);
        add(0, 3'b011, 3'b011, 'h13, 'h20, 'h00, 1, 3'b001, 1, 'h13, 1, 3'b000, 0);
        add(0, 3'b010, 3'b010, 'h00, 'h20, 'h00, 1, 3'b010, 1, 'h20, 1, 3'b000, 0);
        add(0, 3'b000, 3'b000, 'h00, 'h00, 'h00, 1, 3'b000, 0, 'h20, 1, 3'b000, 0);
        // backpressure mid-packet (ptr=2, req1 is next found)
        add(0, 3'b010, 3'b000, 'h00, 'h30, 'h00, 1, 3'b010, 1, 'h30, 0, 3'b010, 1);
        for (int i = 0; i < 5; i++)
            add(0, 3'b010, 3'b000, 'h00, 'h31, 'h00, 0, 3'b000, 1, 'h30, 0, 3'b010, 1);
        add(0, 3'b010, 3'b000, 'h00, 'h31, 'h00, 1, 3'b010, 1, 'h31, 0, 3'b010, 1);
        add(0, 3'b010, 3'b010, 'h00, 'h32, 'h00, 1, 3'b010, 1, 'h32, 1, 3'b000, 0);
        add(0, 3'b000, 3'b000, 'h00, 'h00, 'h00, 1, 3'b000, 0, 'h32, 1, 3'b000, 0);
        // owner stall: req2 locked, req0 waiting
        add(0, 3'b101, 3'b001, 'h60, 'h00, 'h50, 1, 3'b100, 1, 'h50, 0, 3'b100, 1);
        for (int i = 0; i < 3; i++)
            add(0, 3'b001, 3'b001, 'h60, 'h00, 'h50, 1, 3'b100, 0, 'h50, 0, 3'b100, 1);
        add(0, 3'b101, 3'b101, 'h60, 'h00, 'h51, 1, 3'b100, 1, 'h51, 1, 3'b000, 0);
        add(0, 3'b011, 3'b011, 'h60, 'h70, 'h00, 1, 3'b001, 1, 'h60, 1, 3'b000, 0);
        add(0, 3'b010, 3'b010, 'h00, 'h70, 'h00, 1, 3'b010, 1, 'h70, 1, 3'b000, 0);
        add(0, 3'b000, 3'b000, 'h00, 'h00, 'h00, 1, 3'b000, 0, 'h70, 1, 3'b000, 0);
        // reset during 2nd flit of a 4-flit packet
        add(0, 3'b001, 3'b000, 'h80, 'h00, 'h00, 1, 3'b001, 1, 'h80, 0, 3'b001, 1);
        add(1, 3'b001, 3'b000, 'h81, 'h00, 'h00, 1, 3'b000, 0, 'h00, 0, 3'b000, 0);
        add(0, 3'b110, 3'b110, 'h00, 'h90, 'hA0, 1, 3'b010, 1, 'h90, 1, 3'b000, 0);
        add(0, 3'b100, 3'b100, 'h00, 'h00, 'hA0, 1, 3'b100, 1, 'hA0, 1, 3'b000, 0);
        add(0, 3'b000, 3'b000, 'h00, 'h00, 'h00, 1, 3'b000, 0, 'hA0, 1, 3'b000, 0);

        foreach (tbl[i]) begin
            rst            = tbl[i].r;
            bus3.in_valid  = tbl[i].v;
            bus3.in_last   = tbl[i].l;
            bus3.in_flit   = {tbl[i].f2, tbl[i].f1, tbl[i].f0};
            bus3.out_ready = tbl[i].ordy;
            #2;
            chk("in_ready", i, 32'(bus3.in_ready), 32'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk("out_valid", i, 32'(bus3.out_valid), 32'(tbl[i].e_ov));
            chk("out_flit",  i, bus3.out_flit,       tbl[i].e_of);
            chk("out_last",  i, 32'(bus3.out_last),  32'(tbl[i].e_ol));
            chk("grant",     i, 32'(bus3.grant),     32'(tbl[i].e_gr));
            chk("locked",    i, 32'(bus3.locked),    32'(tbl[i].e_lk));
        end

        // N=2 streaming: both sources send 2-flit packets back to back
        bus3.in_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_p = '{0, 0};
        s_k = '{0, 0};
        for (int c = 0; c < 100; c++) begin
            logic [1:0]  acc;
            logic [31:0] exp_f;
            int          pk;
            for (int i = 0; i < 2; i++) begin
                bus2.in_flit[i] = {8'(i), 16'(s_p[i]), 8'(s_k[i])};
                bus2.in_last[i] = (s_k[i] == 1);
            end
            bus2.in_valid  = 2'b11;
            bus2.out_ready = 1'b1;
            #2;
            acc = bus2.in_valid & bus2.in_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    if (s_k[i] == 1) s_p[i]++;
                    s_k[i] = 1 - s_k[i];
                end
            end
            pk    = c / 2;
            exp_f = {8'(pk % 2), 16'(pk / 2), 8'(c % 2)};
            chk("tp_valid", c, 32'(bus2.out_valid), 32'd1);
            chk("tp_flit",  c, bus2.out_flit,       exp_f);
            chk("tp_last",  c, 32'(bus2.out_last),  32'(c % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
